// File: rtl/gato_controlador.sv
// rtl/gato_controlador.sv - tic-tac-toe game sequencer with per-turn timer
// Owns turn grant, timeout, win/draw sequencing and the latched result.
module gato_controlador #(
  parameter int CICLOS_TURNO = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iniciar,
  input  logic       colocado,
  input  logic       hay_ganador,
  output logic       jugador,
  output logic       habilitar,
  output logic       limpiar,
  output logic       timeout,
  output logic [3:0] jugadas,
  output logic       fin,
  output logic [1:0] resultado
);

  localparam int ANCHO = $clog2(CICLOS_TURNO);
  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(CICLOS_TURNO - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LIMPIAR   = 3'd1;
  localparam logic [2:0] TURNO     = 3'd2;
  localparam logic [2:0] VERIFICAR = 3'd3;
  localparam logic [2:0] FIN       = 3'd4;

  logic [2:0]       estado;
  logic [ANCHO-1:0] contador;

  // Status outputs are pure state decodes, so no input reaches an output combinationally.
  assign habilitar = (estado == TURNO);
  assign limpiar   = (estado == LIMPIAR);
  assign fin       = (estado == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      jugador   <= 1'b1;
      jugadas   <= 4'd0;
      resultado <= 2'b00;
      contador  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (estado)
        IDLE: begin
          if (iniciar) estado <= LIMPIAR;
        end
        LIMPIAR: begin
          jugadas   <= 4'd0;
          resultado <= 2'b00;
          jugador   <= 1'b1;
          contador  <= '0;
          estado    <= TURNO;
        end
        TURNO: begin
          // A placement on the expiry cycle takes priority over the timeout.
          if (colocado) begin
            jugadas  <= jugadas + 4'd1;
            contador <= '0;
            estado   <= VERIFICAR;
          end else if (contador == ULTIMO) begin
            timeout  <= 1'b1;
            jugador  <= ~jugador;
            contador <= '0;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        VERIFICAR: begin
          if (hay_ganador) begin
            resultado <= jugador ? 2'b01 : 2'b10;
            estado    <= FIN;
          end else if (jugadas == 4'd9) begin
            resultado <= 2'b11;
            estado    <= FIN;
          end else begin
            jugador <= ~jugador;
            estado  <= TURNO;
          end
        end
        FIN: begin
          if (iniciar) estado <= LIMPIAR;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gato_controlador.sv
// tb/tb_gato_controlador.sv - directed scoreboard bench for gato_controlador
module tb_gato_controlador;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iniciar = 1'b0;
  logic       colocado = 1'b0;
  logic       hay_ganador = 1'b0;
  logic       jugador, habilitar, limpiar, timeout, fin;
  logic [3:0] jugadas;
  logic [1:0] resultado;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [10:0] e;
  } esperado_t;

  esperado_t cola[$];

  logic mj;
  int   mn;

  gato_controlador #(.CICLOS_TURNO(8)) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .colocado(colocado),
    .hay_ganador(hay_ganador), .jugador(jugador), .habilitar(habilitar),
    .limpiar(limpiar), .timeout(timeout), .jugadas(jugadas), .fin(fin),
    .resultado(resultado)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ex(input logic jug, input logic hab, input logic lim,
                                     input logic to, input logic [3:0] jg, input logic fn,
                                     input logic [1:0] res);
    return {jug, hab, lim, to, jg, fn, res};
  endfunction

  task automatic empujar(input string tag, input logic [10:0] e);
    esperado_t x;
    x.tag = tag;
    x.e = e;
    cola.push_back(x);
  endtask

  task automatic comparar();
    esperado_t x;
    logic [10:0] obs;
    x = cola.pop_front();
    obs = {jugador, habilitar, limpiar, timeout, jugadas, fin, resultado};
    total++;
    assert (obs === x.e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.e);
    end
  endtask

  task automatic paso(input logic ini, input logic col, input logic gan,
                      input string tag, input logic [10:0] e);
    iniciar = ini;
    colocado = col;
    hay_ganador = gan;
    empujar(tag, e);
    @(posedge clk);
    #1;
    comparar();
  endtask

  // Plays n placements from a fresh TURNO (X first); hay_ganador only on the last one.
  task automatic jugar(input int n, input logic ganaUltimo);
    mj = 1'b1;
    mn = 0;
    for (int k = 1; k <= n; k++) begin
      mn++;
      paso(0, 1, 0, "verificar", ex(mj, 0, 0, 0, 4'(mn), 0, 2'b00));
      if (k == n && ganaUltimo)
        paso(0, 0, 1, "fin_gana", ex(mj, 0, 0, 0, 4'(mn), 1, mj ? 2'b01 : 2'b10));
      else if (mn == 9)
        paso(0, 0, 0, "fin_empate", ex(mj, 0, 0, 0, 4'd9, 1, 2'b11));
      else begin
        mj = ~mj;
        paso(0, 0, 0, "turno", ex(mj, 1, 0, 0, 4'(mn), 0, 2'b00));
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    empujar("reset", ex(1, 0, 0, 0, 0, 0, 2'b00));
    comparar();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    paso(0, 0, 0, "idle", ex(1, 0, 0, 0, 0, 0, 2'b00));
    paso(1, 0, 0, "limpiar", ex(1, 0, 1, 0, 0, 0, 2'b00));
    paso(0, 0, 0, "turno_x", ex(1, 1, 0, 0, 0, 0, 2'b00));

    jugar(5, 1);
    paso(0, 1, 0, "fin_colocado_ignorado", ex(1, 0, 0, 0, 5, 1, 2'b01));
    paso(0, 0, 0, "fin_mantiene", ex(1, 0, 0, 0, 5, 1, 2'b01));

    paso(1, 0, 0, "limpiar_desde_fin", ex(1, 0, 1, 0, 5, 0, 2'b01));
    paso(0, 0, 0, "juego_nuevo", ex(1, 1, 0, 0, 0, 0, 2'b00));
    jugar(9, 0);

    paso(1, 0, 0, "limpiar_3", ex(1, 0, 1, 0, 9, 0, 2'b11));
    paso(0, 0, 0, "juego_3", ex(1, 1, 0, 0, 0, 0, 2'b00));
    jugar(9, 1);

    paso(1, 0, 0, "limpiar_4", ex(1, 0, 1, 0, 9, 0, 2'b01));
    paso(0, 0, 0, "juego_4", ex(1, 1, 0, 0, 0, 0, 2'b00));
    for (int i = 1; i <= 7; i++)
      paso(1, 0, 0, "turno_iniciar_ignorado", ex(1, 1, 0, 0, 0, 0, 2'b00));
    paso(0, 0, 0, "timeout", ex(0, 1, 0, 1, 0, 0, 2'b00));
    paso(0, 0, 0, "timeout_un_ciclo", ex(0, 1, 0, 0, 0, 0, 2'b00));
    for (int i = 2; i <= 7; i++)
      paso(0, 0, 0, "turno_espera", ex(0, 1, 0, 0, 0, 0, 2'b00));
    paso(0, 1, 0, "colocado_en_expiracion", ex(0, 0, 0, 0, 1, 0, 2'b00));
    paso(0, 1, 0, "verificar_colocado_ignorado", ex(1, 1, 0, 0, 1, 0, 2'b00));
    paso(0, 1, 0, "verificar_antes_reset", ex(1, 0, 0, 0, 2, 0, 2'b00));

    #2 rst = 1'b1;
    #1;
    empujar("reset_en_verificar", ex(1, 0, 0, 0, 0, 0, 2'b00));
    comparar();
    @(posedge clk);
    #1 rst = 1'b0;
    paso(0, 0, 0, "idle_tras_reset", ex(1, 0, 0, 0, 0, 0, 2'b00));

    if (cola.size() != 0) begin
      total++;
      bad++;
      $display("FAIL cola_vacia observed=%0d expected=0", cola.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
